xadc_pwm_scanner: RTL and testbench

XADC_PWM_SCANNER -- requirements
Module: xadc_pwm_scanner

---
 rtl/xadc_pkg.sv | 23 ++
 rtl/xadc_pwm_scanner_pwm_bank.sv | 57 +++++
 rtl/xadc_pwm_scanner.sv | 155 +++++++++++++++
 tb/tb_xadc_pwm_scanner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// ---------------------------------------------------------------------------
// xadc_pkg
// Shared definitions for the XADC scanner and its PWM bank:
//   scan_state_t     - scanner FSM state encoding (IDLE, REQ, WAIT, STORE)
//   DRP_MSB/DRP_LSB  - bit range of the 12-bit conversion result in DRP data
//   DEFAULT_CH_ADDR  - default packed 7-bit DRP address table, channel 0 in LSBs
// ---------------------------------------------------------------------------
package xadc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } scan_state_t;

  localparam int DRP_MSB = 15;
  localparam int DRP_LSB = 4;

  // Channel 0 = 7'h1E, 1 = 7'h17, 2 = 7'h1F, 3 = 7'h16
  localparam logic [27:0] DEFAULT_CH_ADDR = {7'h16, 7'h1F, 7'h17, 7'h1E};

endpackage

// File: rtl/xadc_pwm_scanner_pwm_bank.sv
// ---------------------------------------------------------------------------
// pwm_bank
// Free-running PWM counter with one compare channel per LED. Duty values are
// sampled from 'level' only at the start of a PWM period so a level change
// can never produce a runt or stretched pulse.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   level        packed per-channel duty request, channel 0 in the LSBs
//   led          registered PWM outputs, high while pwm_cnt < duty
// ---------------------------------------------------------------------------
module pwm_bank #(
  parameter int NUM_CH   = 4,
  parameter int PWM_BITS = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH*PWM_BITS-1:0]   level,
  output logic [NUM_CH-1:0]            led
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                at_wrap;

  assign at_wrap = (pwm_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_eff;
    logic                led_reg;

    // In the reload cycle the compare already uses the incoming duty, so the
    // new period starts cleanly with its own value.
    assign duty_eff = at_wrap ? level[gi*PWM_BITS +: PWM_BITS] : duty;
    assign led[gi]  = led_reg;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        duty    <= '0;
        led_reg <= 1'b0;
      end else begin
        if (at_wrap) begin
          duty <= level[gi*PWM_BITS +: PWM_BITS];
        end
        led_reg <= (pwm_cnt < duty_eff);
      end
    end
  end

endmodule

// File: rtl/xadc_pwm_scanner.sv
// ---------------------------------------------------------------------------
// xadc_pwm_scanner
// Round-robin XADC DRP reader. Each eoc (while enabled and idle) triggers one
// DRP read of the current channel; results are accumulated per channel and
// every 2^AVG_LOG2 reads the mean is published and drives that channel's LED
// brightness through pwm_bank.
// Ports:
//   clk, resetn    clock (also DRP clock), asynchronous active-low reset
//   enable         scan enable, gates only the start of new reads
//   eoc            XADC end-of-conversion pulse
//   drdy, do_in    DRP read handshake and data (result in [15:4])
//   den, dwe       DRP enable pulse, write enable (always 0)
//   daddr          DRP address, held for the whole read
//   led            per-channel PWM outputs
//   sample_valid   one-cycle pulse with sample_ch / sample_data
//   timeout_err    sticky DRP timeout flag
// ---------------------------------------------------------------------------
module xadc_pwm_scanner
  import xadc_pkg::*;
#(
  parameter int                    NUM_CH   = 4,
  parameter logic [7*NUM_CH-1:0]   CH_ADDR  = DEFAULT_CH_ADDR,
  parameter int                    AVG_LOG2 = 2,
  parameter int                    PWM_BITS = 8,
  parameter int                    TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              eoc,
  input  logic              drdy,
  input  logic [15:0]       do_in,
  output logic              den,
  output logic              dwe,
  output logic [6:0]        daddr,
  output logic [NUM_CH-1:0] led,
  output logic              sample_valid,
  output logic [3:0]        sample_ch,
  output logic [11:0]       sample_data,
  output logic              timeout_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  scan_state_t       state;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   ch_next;
  logic [TO_W-1:0]   wait_cnt;
  logic [11:0]       sample;
  logic [6:0]        ch_addr;
  logic [ACC_W-1:0]  acc [NUM_CH];
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [11:0]       avg [NUM_CH];
  logic [ACC_W-1:0]  acc_sum;
  logic [11:0]       avg_new;
  logic              group_done;
  logic [NUM_CH*PWM_BITS-1:0] level;
  logic              unused_lsbs;

  assign dwe         = 1'b0;
  assign unused_lsbs = ^do_in[DRP_LSB-1:0];

  assign ch_addr    = CH_ADDR[7*int'(ch) +: 7];
  assign ch_next    = (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
  assign acc_sum    = acc[ch] + ACC_W'(sample);
  assign avg_new    = 12'(acc_sum >> AVG_LOG2);
  // With AVG_LOG2 = 0 the counter is a constant 0 and every read completes a group.
  assign group_done = (cnt[ch] == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      ch           <= '0;
      wait_cnt     <= '0;
      sample       <= '0;
      den          <= 1'b0;
      daddr        <= CH_ADDR[6:0];
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        avg[i] <= '0;
      end
    end else begin
      den          <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && eoc) begin
            state <= REQ;
            den   <= 1'b1;
            daddr <= ch_addr;
          end
        end
        REQ: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (drdy) begin
            sample <= do_in[DRP_MSB:DRP_LSB];
            state  <= STORE;
          end else if (wait_cnt == TO_LAST) begin
            // Abandoned read: accumulator and count stay untouched.
            timeout_err <= 1'b1;
            ch          <= ch_next;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        STORE: begin
          if (group_done) begin
            acc[ch]      <= '0;
            cnt[ch]      <= '0;
            avg[ch]      <= avg_new;
            sample_valid <= 1'b1;
            sample_ch    <= 4'(ch);
            sample_data  <= avg_new;
          end else begin
            acc[ch] <= acc_sum;
            cnt[ch] <= cnt[ch] + 1'b1;
          end
          ch    <= ch_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Brightness uses the top PWM_BITS bits of each channel's average.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_level
    assign level[gi*PWM_BITS +: PWM_BITS] = avg[gi][11 -: PWM_BITS];
  end

  pwm_bank #(
    .NUM_CH   (NUM_CH),
    .PWM_BITS (PWM_BITS)
  ) u_pwm_bank (
    .clk    (clk),
    .resetn (resetn),
    .level  (level),
    .led    (led)
  );

endmodule

// File: tb/tb_xadc_pwm_scanner.sv
// ---------------------------------------------------------------------------
// tb_xadc_pwm_scanner
// Two scanners share one stimulus: dut_a averages 1 read (AVG_LOG2=0),
// dut_b averages 4 reads (default AVG_LOG2=2). Their FSM timing is identical,
// so DRP-side checks use dut_a and averaging checks use both.
// ---------------------------------------------------------------------------
module tb_xadc_pwm_scanner;

  logic        clk = 1'b0;
  logic        resetn, enable, eoc, drdy;
  logic [15:0] do_in;

  logic        den_a, dwe_a, sv_a, to_a;
  logic [6:0]  daddr_a;
  logic [3:0]  led_a, sch_a;
  logic [11:0] sd_a;
  logic        den_b, dwe_b, sv_b, to_b;
  logic [6:0]  daddr_b;
  logic [3:0]  led_b, sch_b;
  logic [11:0] sd_b;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [6:0]  addr_tab [4] = '{7'h1E, 7'h17, 7'h1F, 7'h16};
  logic [11:0] ch0_tab  [4] = '{12'h100, 12'h200, 12'h300, 12'h401};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xadc_pwm_scanner #(.AVG_LOG2(0)) dut_a (
    .clk(clk), .resetn(resetn), .enable(enable), .eoc(eoc), .drdy(drdy),
    .do_in(do_in), .den(den_a), .dwe(dwe_a), .daddr(daddr_a), .led(led_a),
    .sample_valid(sv_a), .sample_ch(sch_a), .sample_data(sd_a), .timeout_err(to_a)
  );

  xadc_pwm_scanner dut_b (
    .clk(clk), .resetn(resetn), .enable(enable), .eoc(eoc), .drdy(drdy),
    .do_in(do_in), .den(den_b), .dwe(dwe_b), .daddr(daddr_b), .led(led_b),
    .sample_valid(sv_b), .sample_ch(sch_b), .sample_data(sd_b), .timeout_err(to_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; enable = 1'b1; eoc = 1'b0; drdy = 1'b0; do_in = '0;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  // One complete read: eoc, den check, drdy 3 cycles after den, sample checks.
  task automatic do_read(input string tag, input int exp_ch, input logic [15:0] data,
                         input logic exp_sv_b, input logic [11:0] exp_sd_b);
    eoc = 1'b1;
    step(1);
    eoc = 1'b0;
    chk($sformatf("%s den", tag), den_a, 1);
    chk($sformatf("%s daddr", tag), daddr_a, addr_tab[exp_ch]);
    step(3);
    drdy = 1'b1; do_in = data;
    step(1);
    drdy = 1'b0; do_in = '0;
    step(1);
    chk($sformatf("%s a_valid", tag), sv_a, 1);
    chk($sformatf("%s a_ch", tag), sch_a, exp_ch);
    chk($sformatf("%s a_data", tag), sd_a, data[15:4]);
    chk($sformatf("%s b_valid", tag), sv_b, exp_sv_b);
    if (exp_sv_b) begin
      chk($sformatf("%s b_ch", tag), sch_b, exp_ch);
      chk($sformatf("%s b_data", tag), sd_b, exp_sd_b);
    end
    step(2);
  endtask

  // Counts den pulses on dut_a while eoc pulses every 10 cycles.
  task automatic eoc_window(output int dens);
    dens = 0;
    for (int k = 0; k < 40; k++) begin
      eoc = (k % 10 == 0);
      step(1);
      if (den_a) dens++;
    end
    eoc = 1'b0;
  endtask

  initial begin
    int ones0, ones1, onesb, t0, found, dens, svs;

    // ---- reset values ----
    resetn = 1'b0; enable = 1'b1; eoc = 1'b0; drdy = 1'b0; do_in = '0;
    step(2);
    chk("rst den", den_a, 0);
    chk("rst dwe", dwe_a, 0);
    chk("rst daddr", daddr_a, 7'h1E);
    chk("rst led", {led_a, led_b}, 0);
    chk("rst valid", {sv_a, sv_b}, 0);
    chk("rst sample", {sch_a, sd_a}, 0);
    chk("rst timeout", {to_a, to_b}, 0);
    resetn = 1'b1;
    step(1);

    // ---- round-robin, single-sample averaging ----
    for (int i = 0; i < 5; i++) begin
      do_read($sformatf("rr%0d", i), i % 4, 16'hABC0, 1'b0, 12'h0);
      step(40);
    end

    // ---- 4-sample averaging: ch0 100,200,300,401 -> 280; ch1 FFF ----
    do_reset();
    for (int r = 0; r < 4; r++) begin
      do_read($sformatf("avg r%0d c0", r), 0, {ch0_tab[r], 4'h0}, r == 3, 12'h280);
      do_read($sformatf("avg r%0d c1", r), 1, 16'hFFF0, r == 3, 12'hFFF);
      do_read($sformatf("avg r%0d c2", r), 2, 16'h0000, r == 3, 12'h000);
      do_read($sformatf("avg r%0d c3", r), 3, 16'h0000, r == 3, 12'h000);
    end
    do_read("avg c0 zero", 0, 16'h0000, 1'b0, 12'h0);

    // ---- PWM: dut_a avg0=000 avg1=FFF, dut_b avg0=280 (duty 0x28) ----
    step(300);
    ones0 = 0; ones1 = 0; onesb = 0;
    for (int k = 0; k < 256; k++) begin
      step(1);
      ones0 += int'(led_a[0]);
      ones1 += int'(led_a[1]);
      onesb += int'(led_b[0]);
    end
    chk("pwm led0 zero duty", ones0, 0);
    chk("pwm led1 max duty", ones1, 255);
    chk("pwm b led0 duty28", onesb, 40);

    // Locate the period start (the single low cycle of the max-duty LED).
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      step(1);
      if (led_a[1] == 1'b0) found = 1;
    end
    chk("pwm period found", found, 1);
    t0 = cyc;
    step(10);
    do_read("pwm chg c1", 1, 16'h0000, 1'b0, 12'h0);
    chk("pwm old duty kept", led_a[1], 1);
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      step(1);
      if (led_a[1] == 1'b0) found = 1;
    end
    chk("pwm change at wrap", cyc - t0, 256);
    ones1 = 0;
    for (int k = 0; k < 256; k++) begin
      step(1);
      ones1 += int'(led_a[1]);
    end
    chk("pwm new duty zero", ones1, 0);

    // ---- DRP timeout on ch0 ----
    do_reset();
    do_in = 16'hFFF0;
    eoc = 1'b1;
    step(1);
    eoc = 1'b0;
    chk("to den", den_a, 1);
    step(255);
    chk("to before limit", to_a, 0);
    step(1);
    chk("to flag a", to_a, 1);
    chk("to flag b", to_b, 1);
    chk("to no sample", sv_a, 0);
    step(1);
    chk("to no store", sv_a, 0);
    do_in = '0;
    step(2);
    for (int c = 1; c < 4; c++) do_read($sformatf("to pre c%0d", c), c, 16'h0000, 1'b0, 12'h0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        do_read($sformatf("to r%0d c%0d", r, c), c, (c == 0) ? 16'h8000 : 16'h0000,
                (c == 0) ? (r == 3) : (r == 2), (c == 0) ? 12'h800 : 12'h000);
      end
    end
    chk("to sticky", to_a, 1);

    // ---- reset while waiting for drdy ----
    do_read("rw c0", 0, 16'h5550, 1'b0, 12'h0);
    eoc = 1'b1;
    step(1);
    eoc = 1'b0;
    chk("rw daddr", daddr_a, 7'h17);
    step(1);
    #2 resetn = 1'b0;
    #1;
    chk("rw den", den_a, 0);
    chk("rw daddr rst", daddr_a, 7'h1E);
    chk("rw timeout", {to_a, to_b}, 0);
    chk("rw sample", {sv_a, sch_a, sd_a}, 0);
    chk("rw led", {led_a, led_b}, 0);
    step(1);
    resetn = 1'b1;
    step(2);
    drdy = 1'b1; do_in = 16'hABC0;
    step(1);
    drdy = 1'b0; do_in = '0;
    svs = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      svs += int'(sv_a) + int'(sv_b);
    end
    chk("rw late drdy", svs, 0);
    do_read("rw after", 0, 16'h1230, 1'b0, 12'h0);

    // ---- enable gating ----
    enable = 1'b0;
    eoc_window(dens);
    chk("en off no den", dens, 0);
    enable = 1'b1;
    eoc = 1'b1;
    step(1);
    eoc = 1'b0;
    chk("en den", den_a, 1);
    chk("en daddr", daddr_a, 7'h17);
    step(1);
    enable = 1'b0;
    step(2);
    drdy = 1'b1; do_in = 16'h7770;
    step(1);
    drdy = 1'b0; do_in = '0;
    step(1);
    chk("en drop completes", sv_a, 1);
    chk("en drop data", sd_a, 12'h777);
    eoc_window(dens);
    chk("en drop no den", dens, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
